// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice: state encoding and default sizing.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    LAP   = 3'd3,
    SAT   = 3'd4
  } sw_state_t;

  localparam int CNT_W_DEF      = 14;
  localparam int MAX_TENTHS_DEF = 9999;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced button level; the history flop resets to
// RST_VAL so a button held through reset release produces no edge.
module btn_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_edge
);

  logic r_btn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_btn_q <= RST_VAL;
    else     r_btn_q <= i_btn;
  end

  assign o_edge = i_btn & ~r_btn_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button edges drive counter enable/clear and the display value.
// Lap-freeze support is compiled in only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MAX_TENTHS = MAX_TENTHS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_ss,
  input  logic             btn_lr,
  input  logic [CNT_W-1:0] count_in,
  output logic             cnt_enable,
  output logic             cnt_clear,
  output logic [CNT_W-1:0] disp_value,
  output logic             running,
  output logic             lap_active,
  output logic             saturated
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_TENTHS);

  logic             w_ss, w_lr, w_sat, w_clear;
  sw_state_t        r_state, w_next;
  logic [CNT_W-1:0] w_disp;
  logic             r_enable, r_clear, r_running, r_saturated;
  logic [CNT_W-1:0] r_disp;

  btn_edge #(.RST_VAL(1'b1)) u_edge_ss (.clk(clk), .rst(rst), .i_btn(btn_ss), .o_edge(w_ss));
  btn_edge #(.RST_VAL(1'b1)) u_edge_lr (.clk(clk), .rst(rst), .i_btn(btn_lr), .o_edge(w_lr));

  // >= so a counter that skips past the limit still saturates
  assign w_sat = (count_in >= MAX_V);

`ifdef STOPWATCH_LAP_EN
  logic [CNT_W-1:0] r_lap, w_lap;
  logic             r_lap_active;
`endif

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
    w_lap   = r_lap;
`endif
    case (r_state)
      IDLE: begin
        if (w_ss)      w_next = RUN;
        else if (w_lr) w_clear = 1'b1;
      end
      RUN: begin
        if (w_sat)     w_next = SAT;
        else if (w_ss) w_next = PAUSE;
`ifdef STOPWATCH_LAP_EN
        else if (w_lr) begin
          w_next = LAP;
          w_lap  = count_in;
        end
`endif
      end
`ifdef STOPWATCH_LAP_EN
      LAP: begin
        if (w_sat)     w_next = SAT;
        else if (w_ss) w_next = PAUSE;
        else if (w_lr) w_next = RUN;
      end
`endif
      PAUSE: begin
        if (w_ss) w_next = RUN;
        else if (w_lr) begin
          w_next  = IDLE;
          w_clear = 1'b1;
        end
      end
      SAT: begin
        if (w_lr) begin
          w_next  = IDLE;
          w_clear = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Display source follows the state being entered, so it lands with the state change
  always_comb begin
    w_disp = '0;
    case (w_next)
      RUN, PAUSE: w_disp = count_in;
`ifdef STOPWATCH_LAP_EN
      LAP:        w_disp = w_lap;
`endif
      SAT:        w_disp = MAX_V;
      default:    w_disp = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_enable    <= 1'b0;
      r_clear     <= 1'b0;
      r_running   <= 1'b0;
      r_saturated <= 1'b0;
      r_disp      <= '0;
    end else begin
      r_state     <= w_next;
      r_enable    <= (w_next == RUN) || (w_next == LAP);
      r_clear     <= w_clear;
      r_running   <= (w_next == RUN) || (w_next == LAP);
      r_saturated <= (w_next == SAT);
      r_disp      <= w_disp;
    end
  end

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lap        <= '0;
      r_lap_active <= 1'b0;
    end else begin
      r_lap        <= w_lap;
      r_lap_active <= (w_next == LAP);
    end
  end
  assign lap_active = r_lap_active;
`else
  assign lap_active = 1'b0;
`endif

  assign cnt_enable = r_enable;
  assign cnt_clear  = r_clear;
  assign running    = r_running;
  assign saturated  = r_saturated;
  assign disp_value = r_disp;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed scoreboard bench for stopwatch_ctrl; lap steps follow STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_ss, btn_lr;
  logic [13:0] count_in;
  logic        cnt_enable, cnt_clear, running, lap_active, saturated;
  logic [13:0] disp_value;

  typedef struct {
    string       tag;
    logic [18:0] vec;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  stopwatch_ctrl dut (
    .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lr(btn_lr), .count_in(count_in),
    .cnt_enable(cnt_enable), .cnt_clear(cnt_clear), .disp_value(disp_value),
    .running(running), .lap_active(lap_active), .saturated(saturated)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic en, input logic clr, input logic run,
                      input logic lap, input logic sat, input logic [13:0] disp);
    exp_t e;
    e.tag = tag;
    e.vec = {en, clr, run, lap, sat, disp};
    q.push_back(e);
  endtask

  task automatic chk_now();
    exp_t        e;
    logic [18:0] obs;
    obs = {cnt_enable, cnt_clear, running, lap_active, saturated, disp_value};
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h expected an entry", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.vec) else begin
        errors++;
        $error("FAIL %s: observed en/clr/run/lap/sat/disp=%b%b%b%b%b/%0d expected %b%b%b%b%b/%0d",
               e.tag, obs[18], obs[17], obs[16], obs[15], obs[14], obs[13:0],
               e.vec[18], e.vec[17], e.vec[16], e.vec[15], e.vec[14], e.vec[13:0]);
      end
    end
  endtask

  // Drive one cycle of stimulus, record what the edge must produce, then compare
  task automatic cyc(input logic ss, input logic lr, input int cnt, input string tag,
                     input logic en, input logic clr, input logic run, input logic lap,
                     input logic sat, input int disp);
    btn_ss   = ss;
    btn_lr   = lr;
    count_in = 14'(cnt);
    push(tag, en, clr, run, lap, sat, 14'(disp));
    @(posedge clk);
    #1;
    chk_now();
  endtask

  initial begin
    rst = 1'b1; btn_ss = 1'b0; btn_lr = 1'b0; count_in = '0;
    repeat (2) @(posedge clk);
    #1;
    push("reset", 0, 0, 0, 0, 0, 0);
    chk_now();
    rst = 1'b0;

    cyc(0, 0, 0, "idle", 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, "start", 1, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) cyc(1, 0, k, "ss_held", 1, 0, 1, 0, 0, k);
    cyc(0, 0, 42, "run42", 1, 0, 1, 0, 0, 42);
    cyc(1, 0, 42, "pause", 0, 0, 0, 0, 0, 42);
    cyc(0, 0, 42, "pause_hold", 0, 0, 0, 0, 0, 42);
    cyc(1, 0, 100, "resume", 1, 0, 1, 0, 0, 100);
    cyc(0, 0, 120, "run120", 1, 0, 1, 0, 0, 120);
`ifdef STOPWATCH_LAP_EN
    cyc(0, 1, 120, "lap", 1, 0, 1, 1, 0, 120);
    cyc(0, 1, 135, "lap_hold", 1, 0, 1, 1, 0, 120);
    cyc(0, 0, 150, "lap_freeze", 1, 0, 1, 1, 0, 120);
    cyc(0, 1, 150, "unlap", 1, 0, 1, 0, 0, 150);
`else
    cyc(0, 1, 120, "lr_ignored", 1, 0, 1, 0, 0, 120);
    cyc(0, 1, 135, "lr_ign_hold", 1, 0, 1, 0, 0, 135);
    cyc(0, 0, 150, "lr_ign_run", 1, 0, 1, 0, 0, 150);
`endif
    cyc(0, 0, 150, "run150", 1, 0, 1, 0, 0, 150);

    cyc(1, 0, 150, "pause2", 0, 0, 0, 0, 0, 150);
    cyc(0, 0, 150, "pause2_hold", 0, 0, 0, 0, 0, 150);
    cyc(0, 1, 150, "pause_clear", 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 150, "clear_once", 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, "idle2", 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, "idle_clear", 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, "idle_after", 0, 0, 0, 0, 0, 0);

    cyc(1, 0, 9990, "start_sat", 1, 0, 1, 0, 0, 9990);
    cyc(0, 0, 9998, "run9998", 1, 0, 1, 0, 0, 9998);
    cyc(0, 0, 10000, "sat_over", 0, 0, 0, 0, 1, 9999);
    cyc(1, 0, 10000, "sat_ss_ign", 0, 0, 0, 0, 1, 9999);
    cyc(0, 0, 10000, "sat_hold", 0, 0, 0, 0, 1, 9999);
    cyc(0, 1, 10000, "sat_clear", 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, "idle3", 0, 0, 0, 0, 0, 0);

    cyc(1, 0, 9998, "start_eq", 1, 0, 1, 0, 0, 9998);
    cyc(0, 0, 9999, "sat_equal", 0, 0, 0, 0, 1, 9999);
    cyc(0, 1, 9999, "sat_eq_clr", 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, "idle4", 0, 0, 0, 0, 0, 0);

    cyc(1, 0, 5, "start_sim", 1, 0, 1, 0, 0, 5);
    cyc(0, 0, 6, "run6", 1, 0, 1, 0, 0, 6);
    cyc(1, 1, 7, "simul_edges", 0, 0, 0, 0, 0, 7);
    cyc(0, 0, 7, "simul_hold", 0, 0, 0, 0, 0, 7);
    cyc(0, 1, 7, "simul_clear", 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, "idle5", 0, 0, 0, 0, 0, 0);

    cyc(1, 0, 9000, "start_prio", 1, 0, 1, 0, 0, 9000);
    cyc(0, 0, 9500, "run9500", 1, 0, 1, 0, 0, 9500);
    cyc(1, 1, 10005, "sat_prio", 0, 0, 0, 0, 1, 9999);
    cyc(0, 0, 10005, "sat_prio_hold", 0, 0, 0, 0, 1, 9999);
    cyc(0, 1, 10005, "sat_prio_clr", 0, 1, 0, 0, 0, 0);

    rst = 1'b1; btn_ss = 1'b1; btn_lr = 1'b0; count_in = '0;
    repeat (2) @(posedge clk);
    #1;
    push("rst_held_btn", 0, 0, 0, 0, 0, 0);
    chk_now();
    rst = 1'b0;
    cyc(1, 0, 0, "held_no_start", 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, "held_still", 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, "held_release", 0, 0, 0, 0, 0, 0);

    cyc(1, 0, 33, "start_async", 1, 0, 1, 0, 0, 33);
    cyc(0, 0, 34, "run34", 1, 0, 1, 0, 0, 34);
    #2;
    rst = 1'b1;
    #1;
    push("async_rst", 0, 0, 0, 0, 0, 0);
    chk_now();
    @(posedge clk);
    #1;
    push("async_rst_hold", 0, 0, 0, 0, 0, 0);
    chk_now();
    rst = 1'b0;
    cyc(0, 0, 34, "post_rst_idle", 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control FSM that sequences the tenth-of-second counter to form a stopwatch.
- Turns two debounced push-button levels (start/stop, lap/reset) into the counter's enable and clear, and selects the value sent to the 7-segment display driver.
- Handles freezing a lap time and saturating at the display limit.
- Sits between the button debouncers, the tenth-second counter and the BCD/7-segment display path.

Parameters:
- CNT_W, 14, width of the counter value and the display value.
- MAX_TENTHS, 9999, saturation limit in tenths of a second (999.9 s on 4 digits); must be < 2**CNT_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- btn_ss  in  1  start/stop button, debounced and synchronised level.
- btn_lr  in  1  lap/reset button, debounced and synchronised level.
- count_in  in  CNT_W  current tenth count from the counter.
- cnt_enable  out  1  enable to the counter; registered.
- cnt_clear  out  1  one-cycle synchronous clear pulse to the counter; registered.
- disp_value  out  CNT_W  value for the display path; registered.
- running  out  1  high in RUN or LAP.
- lap_active  out  1  high in LAP.
- saturated  out  1  high in SAT.

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs = 0.
  - lap_reg = 0.
  - Button history registers = 1, so a button held through reset release produces no edge.
- Edge detection:
  - edge = btn & ~btn_q. btn_q updates every clk.
  - A level held high yields exactly one edge.
- Latency: the state, cnt_enable, cnt_clear and the status outputs all update on the same clk edge that samples the button edge. cnt_enable is therefore valid 1 cycle after the button rises.
- States and transitions (priority order within a state):
  - IDLE:
    - ss -> RUN.
    - lr -> stay in IDLE and pulse cnt_clear.
  - RUN:
    - count_in >= MAX_TENTHS -> SAT.
    - Else ss -> PAUSE.
    - Else lr -> LAP, with lap_reg <= count_in.
  - LAP:
    - count_in >= MAX_TENTHS -> SAT.
    - Else ss -> PAUSE.
    - Else lr -> RUN.
  - PAUSE:
    - ss -> RUN.
    - Else lr -> IDLE and pulse cnt_clear.
  - SAT:
    - ss ignored.
    - lr -> IDLE and pulse cnt_clear.
- Simultaneous ss and lr edges: ss wins and the lr edge is discarded. Saturation outranks both.
- cnt_enable = 1 exactly while the next state is RUN or LAP.
- cnt_clear is high for one cycle only, in the cycle the state enters IDLE via lr or on an lr edge while already in IDLE. It never coincides with cnt_enable = 1.
- disp_value, registered one cycle after the source:
  - IDLE: 0.
  - RUN / PAUSE: count_in.
  - LAP: lap_reg.
  - SAT: MAX_TENTHS. This clamps any overshoot of count_in.
- The comparison uses >=, so a count that jumps past MAX_TENTHS still saturates.
- Asynchronous reset mid-operation returns to the reset values immediately. No cnt_clear is issued, because the counter shares rst.
- Illegal or unused state encodings recover to IDLE on the next clk.

Optional Feature:
- Macro: STOPWATCH_LAP_EN
- Defined:
  - LAP state and lap_reg exist as described above.
- Undefined:
  - No LAP state and no lap_reg.
  - In RUN, an lr edge is ignored.
  - lap_active is tied 0.
  - All other behaviour is unchanged.

Decomposition:
- Shared package stopwatch_pkg holds:
  - State enumeration: IDLE, RUN, PAUSE, LAP, SAT, with explicit 3-bit encoding.
  - CNT_W default.
  - MAX_TENTHS default.
- One sub-module, btn_edge: parameterised reset-to-1 history flop plus rising-edge detect. It is instantiated twice, once for btn_ss and once for btn_lr.

Test Plan:
- Start/stop: after reset, pulse btn_ss high for 5 cycles.
  - Expect cnt_enable = 1 one cycle later, a single edge only, running = 1.
  - Second press -> cnt_enable = 0, state PAUSE, disp_value tracks count_in = 42.
- Lap freeze: in RUN with count_in = 120, press btn_lr.
  - Expect lap_active = 1 and disp_value holding 120 while count_in ramps to 150.
  - Press btn_lr again -> disp_value = 150 next cycle.
- Reset path: in PAUSE, press btn_lr.
  - Expect a single-cycle cnt_clear = 1, state IDLE, disp_value = 0, cnt_enable stays 0.
- Saturation: in RUN, drive count_in 9998 -> 10000.
  - Expect saturated = 1, cnt_enable = 0 and disp_value = 9999 on the next cycle.
  - btn_ss is ignored; btn_lr gives cnt_clear and IDLE.
- Simultaneous edges: in RUN, raise btn_ss and btn_lr on the same cycle.
  - Expect PAUSE, no LAP, no cnt_clear.
- Reset robustness:
  - Hold btn_ss high across rst release -> no start.
  - Assert rst mid-RUN -> all outputs 0 asynchronously.
